switch_debouncer: RTL and testbench

Conditions a raw mechanical switch/button input into a clean, glitch-free level for downstream edge-detection and tick-generation stages. Raw input is synchronised to clk, then filtered by an FSM with a stability counter. The filtered level changes only after the input holds a new value for STABLE_CNT consecutive cycles. Also emits one-cycle rise/fall ticks for consumers that need a pulse rather than a level.

---
 rtl/debounce_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 22 ++
 rtl/switch_debouncer.sv | 105 ++++++++++
 tb/tb_switch_debouncer.sv | 121 ++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared definitions for the switch debouncer and related input-conditioning stages.
package debounce_pkg;

  // Filter FSM states; the MSB doubles as the debounced level.
  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT1 = 2'b01,
    ONE   = 2'b10,
    WAIT0 = 2'b11
  } db_state_t;

  // Short stability window used for simulation builds.
  localparam int unsigned SIM_STABLE_CNT = 4;

  // Debounced level presented while the FSM sits in a given state.
  function automatic logic level_of(input db_state_t s);
    return (s == ONE) || (s == WAIT0);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // First flop may go metastable; second flop gives it a cycle to settle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/switch_debouncer.sv
// Debounces a raw mechanical switch: synchronise, require a stable run of
// STABLE_CNT cycles before changing level, and emit one-cycle rise/fall ticks.
module switch_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CNT = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic db_level,
  output logic db_rise,
  output logic db_fall
);

  localparam int unsigned CNT_W = $clog2(STABLE_CNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  logic             sw_s;
  db_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             rise_nxt, fall_nxt;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (sw),
    .q   (sw_s)
  );

  // State and stability counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ZERO;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic; the terminal compare leaves WAIT before cnt can wrap.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ZERO: begin
        if (sw_s) begin
          state_nxt = WAIT1;
          cnt_nxt   = '0;
        end
      end
      WAIT1: begin
        if (!sw_s) begin
          state_nxt = ZERO;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ONE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ONE: begin
        if (!sw_s) begin
          state_nxt = WAIT0;
          cnt_nxt   = '0;
        end
      end
      WAIT0: begin
        if (sw_s) begin
          state_nxt = ONE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ZERO;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ZERO;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Ticks fire only on completed WAIT transitions, never on bounce-back.
  always_comb begin
    rise_nxt = (state == WAIT1) && (state_nxt == ONE);
    fall_nxt = (state == WAIT0) && (state_nxt == ZERO);
  end

  // Registered outputs, computed from next state so they align with the state change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_level <= 1'b0;
      db_rise  <= 1'b0;
      db_fall  <= 1'b0;
    end else begin
      db_level <= level_of(state_nxt);
      db_rise  <= rise_nxt;
      db_fall  <= fall_nxt;
    end
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with STABLE_CNT=4.
module tb_switch_debouncer;
  import debounce_pkg::*;

  logic clk;
  logic rst;
  logic sw;
  logic db_level;
  logic db_rise;
  logic db_fall;

  typedef struct {
    logic       sw;
    logic [2:0] exp;  // {level, rise, fall} after the edge that samples sw
  } vec_t;

  vec_t        vecs[$];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  switch_debouncer #(.STABLE_CNT(SIM_STABLE_CNT)) dut (
    .clk      (clk),
    .rst      (rst),
    .sw       (sw),
    .db_level (db_level),
    .db_rise  (db_rise),
    .db_fall  (db_fall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic add(input int unsigned n, input logic s, input logic [2:0] e);
    vec_t v;
    v.sw  = s;
    v.exp = e;
    repeat (n) vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [2:0] exp);
    logic [2:0] got;
    got = {db_level, db_rise, db_fall};
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: level/rise/fall got %b want %b at %0t", name, got, exp, $time);
    end
  endtask

  initial begin
    // Clean press: first high sample at index 0, level/rise after index 6.
    add(6, 1'b1, 3'b000); add(1, 1'b1, 3'b110); add(3, 1'b1, 3'b100);
    // Clean release: first low sample at index 10, fall after index 16.
    add(6, 1'b0, 3'b100); add(1, 1'b0, 3'b001); add(3, 1'b0, 3'b000);
    // Bouncy press: 1,1,1,0,1,1,0 then held; rise 6 edges after the held run starts.
    add(3, 1'b1, 3'b000); add(1, 1'b0, 3'b000); add(2, 1'b1, 3'b000);
    add(1, 1'b0, 3'b000); add(6, 1'b1, 3'b000); add(1, 1'b1, 3'b110);
    add(3, 1'b1, 3'b100);
    // Three-cycle low glitch while ONE, then a held low that completes.
    add(3, 1'b0, 3'b100); add(5, 1'b1, 3'b100); add(6, 1'b0, 3'b100);
    add(1, 1'b0, 3'b001); add(3, 1'b0, 3'b000);
    // High for one sample short of a full window: no level change, no tick.
    add(4, 1'b1, 3'b000); add(6, 1'b0, 3'b000);

    // Initial reset asserted before any clock edge.
    sw  = 1'b1;
    rst = 1'b1;
    #2 rst = 1'b0;
    #1 check("reset_async", 3'b000);
    @(negedge clk);
    sw = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      check("post_reset_idle", 3'b000);
    end

    foreach (vecs[i]) begin
      sw = vecs[i].sw;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Reset during a rise tick: outputs drop without waiting for a clock edge.
    sw = 1'b1;
    repeat (7) @(posedge clk);
    #1 check("press_before_reset", 3'b110);
    #2 rst = 1'b0;
    #1 check("reset_mid_tick", 3'b000);
    @(negedge clk);
    sw  = 1'b0;
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      check("idle_after_tick_reset", 3'b000);
    end

    // Reset partway through WAIT1; the count must restart from scratch.
    sw = 1'b1;
    repeat (5) @(posedge clk);
    #1 check("mid_wait1", 3'b000);
    @(negedge clk);
    rst = 1'b0;
    #1 check("reset_mid_wait1", 3'b000);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 9; k++) begin
      logic [2:0] e;
      e = (k == 6) ? 3'b110 : (k > 6) ? 3'b100 : 3'b000;
      @(posedge clk); #1;
      check($sformatf("recount_k%0d", k), e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
